// File: rtl/rob.sv
// Reorder buffer for the out-of-order RV32I core: allocates entries in program order,
// collects CDB results, answers operand queries and retires one entry per cycle.
module rob #(
  parameter int ROB_BIT = 4
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               rdy_in,
  input  logic               issue_valid,
  input  logic [1:0]         issue_type,
  input  logic [4:0]         issue_rd,
  input  logic [31:0]        issue_pc,
  input  logic               issue_pred_jump,
  input  logic               issue_ready,
  input  logic [31:0]        issue_value,
  output logic               full,
  output logic [ROB_BIT-1:0] issue_entry,
  output logic               rob_issue_reg,
  output logic [4:0]         issue_reg_id,
  output logic [ROB_BIT-1:0] issue_rob_entry,
  input  logic               wb_valid,
  input  logic [ROB_BIT-1:0] wb_entry,
  input  logic [31:0]        wb_value,
  input  logic               wb_jump,
  input  logic [31:0]        wb_target,
  input  logic [ROB_BIT-1:0] get_rob_entry1,
  input  logic [ROB_BIT-1:0] get_rob_entry2,
  output logic               ready1,
  output logic               ready2,
  output logic [31:0]        value1,
  output logic [31:0]        value2,
  output logic               rob_commit_reg,
  output logic [4:0]         commit_reg_id,
  output logic [31:0]        commit_reg_data,
  output logic [ROB_BIT-1:0] commit_rob_entry,
  output logic               commit_store,
  output logic [ROB_BIT-1:0] commit_store_entry,
  output logic               rob_clear_up,
  output logic [31:0]        clear_pc,
  output logic               exit_out
);

  localparam int N = 1 << ROB_BIT;
  localparam logic [ROB_BIT:0] CNT_FULL = {1'b1, {ROB_BIT{1'b0}}};

  typedef enum logic [1:0] {
    T_REG    = 2'd0,
    T_STORE  = 2'd1,
    T_BRANCH = 2'd2,
    T_EXIT   = 2'd3
  } rob_type_e;

  logic [ROB_BIT-1:0] head_q, head_d, tail_q, tail_d;
  logic [ROB_BIT:0]   count_q, count_d;
  logic [N-1:0]       busy_q, busy_d, ready_q, ready_d;
  logic [N-1:0]       pred_q, pred_d, jump_q, jump_d;
  rob_type_e          type_q [N];
  rob_type_e          type_d [N];
  logic [4:0]         rd_q [N];
  logic [4:0]         rd_d [N];
  logic [31:0]        pc_q [N];
  logic [31:0]        pc_d [N];
  logic [31:0]        value_q [N];
  logic [31:0]        value_d [N];
  logic [31:0]        target_q [N];
  logic [31:0]        target_d [N];

  logic               creg_q, creg_d, cstore_q, cstore_d, clear_q, clear_d, exit_q, exit_d;
  logic [4:0]         cid_q, cid_d;
  logic [31:0]        cdata_q, cdata_d, clear_pc_q, clear_pc_d;
  logic [ROB_BIT-1:0] centry_q, centry_d, sentry_q, sentry_d;

  logic issue_fire, wb_fire, commit_fire, mispredict;

  // Issue handshake: the decoder presents issue_valid with its payload and holds it until the
  // cycle in which issue_valid && !full && !rob_clear_up; that edge is the one that accepts it.
  assign full        = (count_q == CNT_FULL);
  assign issue_fire  = issue_valid && !full && !clear_q;
  assign wb_fire     = wb_valid && !clear_q && busy_q[wb_entry];
  assign commit_fire = busy_q[head_q] && ready_q[head_q];
  assign mispredict  = commit_fire && (type_q[head_q] == T_BRANCH) &&
                       (jump_q[head_q] != pred_q[head_q]);

  assign issue_entry     = tail_q;
  assign issue_reg_id    = issue_rd;
  assign issue_rob_entry = tail_q;
  assign rob_issue_reg   = issue_fire && (issue_rd != 5'd0) &&
                           ((issue_type == T_REG) || (issue_type == T_BRANCH));

  assign ready1 = ready_q[get_rob_entry1] || (wb_valid && (wb_entry == get_rob_entry1));
  assign ready2 = ready_q[get_rob_entry2] || (wb_valid && (wb_entry == get_rob_entry2));
  assign value1 = (wb_valid && (wb_entry == get_rob_entry1)) ? wb_value : value_q[get_rob_entry1];
  assign value2 = (wb_valid && (wb_entry == get_rob_entry2)) ? wb_value : value_q[get_rob_entry2];

  assign rob_commit_reg     = creg_q;
  assign commit_reg_id      = cid_q;
  assign commit_reg_data    = cdata_q;
  assign commit_rob_entry   = centry_q;
  assign commit_store       = cstore_q;
  assign commit_store_entry = sentry_q;
  assign rob_clear_up       = clear_q;
  assign clear_pc           = clear_pc_q;
  assign exit_out           = exit_q;

  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    busy_d     = busy_q;
    ready_d    = ready_q;
    pred_d     = pred_q;
    jump_d     = jump_q;
    type_d     = type_q;
    rd_d       = rd_q;
    pc_d       = pc_q;
    value_d    = value_q;
    target_d   = target_q;
    creg_d     = 1'b0;
    cid_d      = cid_q;
    cdata_d    = cdata_q;
    centry_d   = centry_q;
    cstore_d   = 1'b0;
    sentry_d   = sentry_q;
    clear_d    = 1'b0;
    clear_pc_d = clear_pc_q;
    exit_d     = exit_q;

    if (wb_fire) begin
      ready_d[wb_entry]  = 1'b1;
      value_d[wb_entry]  = wb_value;
      jump_d[wb_entry]   = wb_jump;
      target_d[wb_entry] = wb_target;
    end

    if (commit_fire) begin
      busy_d[head_q] = 1'b0;
      head_d         = head_q + 1'b1;
      case (type_q[head_q])
        T_REG, T_BRANCH: begin
          creg_d   = 1'b1;
          cid_d    = rd_q[head_q];
          cdata_d  = (rd_q[head_q] == 5'd0) ? 32'd0 : value_q[head_q];
          centry_d = head_q;
        end
        T_STORE: begin
          cstore_d = 1'b1;
          sentry_d = head_q;
        end
        T_EXIT:  exit_d = 1'b1;
        default: ;
      endcase
    end

    if (mispredict) begin
      busy_d     = '0;
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      clear_d    = 1'b1;
      clear_pc_d = jump_q[head_q] ? target_q[head_q] : pc_q[head_q] + 32'd4;
    end else begin
      if (issue_fire) begin
        busy_d[tail_q]   = 1'b1;
        ready_d[tail_q]  = issue_ready;
        type_d[tail_q]   = rob_type_e'(issue_type);
        rd_d[tail_q]     = issue_rd;
        pc_d[tail_q]     = issue_pc;
        pred_d[tail_q]   = issue_pred_jump;
        value_d[tail_q]  = issue_value;
        // A branch resolved at issue (JAL) follows its prediction, so it never flushes.
        jump_d[tail_q]   = issue_pred_jump;
        target_d[tail_q] = 32'd0;
        tail_d           = tail_q + 1'b1;
      end
      count_d = count_q + {{ROB_BIT{1'b0}}, issue_fire} - {{ROB_BIT{1'b0}}, commit_fire};
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      busy_q     <= '0;
      ready_q    <= '0;
      pred_q     <= '0;
      jump_q     <= '0;
      type_q     <= '{default: T_REG};
      rd_q       <= '{default: 5'd0};
      pc_q       <= '{default: 32'd0};
      value_q    <= '{default: 32'd0};
      target_q   <= '{default: 32'd0};
      creg_q     <= 1'b0;
      cid_q      <= '0;
      cdata_q    <= '0;
      centry_q   <= '0;
      cstore_q   <= 1'b0;
      sentry_q   <= '0;
      clear_q    <= 1'b0;
      clear_pc_q <= '0;
      exit_q     <= 1'b0;
    end else if (rdy_in) begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      busy_q     <= busy_d;
      ready_q    <= ready_d;
      pred_q     <= pred_d;
      jump_q     <= jump_d;
      type_q     <= type_d;
      rd_q       <= rd_d;
      pc_q       <= pc_d;
      value_q    <= value_d;
      target_q   <= target_d;
      creg_q     <= creg_d;
      cid_q      <= cid_d;
      cdata_q    <= cdata_d;
      centry_q   <= centry_d;
      cstore_q   <= cstore_d;
      sentry_q   <= sentry_d;
      clear_q    <= clear_d;
      clear_pc_q <= clear_pc_d;
      exit_q     <= exit_d;
    end
  end

endmodule

// File: tb/tb_rob.sv
// Bench for rob: directed scenarios followed by random traffic, all checked against a
// program-order queue model of the reorder buffer.
module tb_rob;
  localparam int RB = 4;
  localparam int N  = 1 << RB;

  logic          clk_in = 1'b0;
  logic          rst_in, rdy_in;
  logic          issue_valid, issue_pred_jump, issue_ready;
  logic [1:0]    issue_type;
  logic [4:0]    issue_rd;
  logic [31:0]   issue_pc, issue_value;
  logic          full, rob_issue_reg;
  logic [RB-1:0] issue_entry, issue_rob_entry;
  logic [4:0]    issue_reg_id;
  logic          wb_valid, wb_jump;
  logic [RB-1:0] wb_entry;
  logic [31:0]   wb_value, wb_target;
  logic [RB-1:0] get_rob_entry1, get_rob_entry2;
  logic          ready1, ready2;
  logic [31:0]   value1, value2;
  logic          rob_commit_reg, commit_store, rob_clear_up, exit_out;
  logic [4:0]    commit_reg_id;
  logic [31:0]   commit_reg_data, clear_pc;
  logic [RB-1:0] commit_rob_entry, commit_store_entry;

  always #5 clk_in = ~clk_in;

  rob #(.ROB_BIT(RB)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .issue_valid(issue_valid), .issue_type(issue_type), .issue_rd(issue_rd),
    .issue_pc(issue_pc), .issue_pred_jump(issue_pred_jump), .issue_ready(issue_ready),
    .issue_value(issue_value), .full(full), .issue_entry(issue_entry),
    .rob_issue_reg(rob_issue_reg), .issue_reg_id(issue_reg_id), .issue_rob_entry(issue_rob_entry),
    .wb_valid(wb_valid), .wb_entry(wb_entry), .wb_value(wb_value), .wb_jump(wb_jump),
    .wb_target(wb_target), .get_rob_entry1(get_rob_entry1), .get_rob_entry2(get_rob_entry2),
    .ready1(ready1), .ready2(ready2), .value1(value1), .value2(value2),
    .rob_commit_reg(rob_commit_reg), .commit_reg_id(commit_reg_id),
    .commit_reg_data(commit_reg_data), .commit_rob_entry(commit_rob_entry),
    .commit_store(commit_store), .commit_store_entry(commit_store_entry),
    .rob_clear_up(rob_clear_up), .clear_pc(clear_pc), .exit_out(exit_out)
  );

  typedef struct {
    int          idx;
    logic [1:0]  typ;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic        pred;
    logic        rdy;
    logic [31:0] val;
    logic        jmp;
    logic [31:0] tgt;
  } ent_t;

  ent_t        mq[$];
  int          m_tail;
  logic        m_clear;
  logic        e_creg, e_st, e_clr, e_exit;
  logic [4:0]  e_cid;
  logic [31:0] e_cdata, e_clrpc;
  int          e_centry, e_stentry;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          unr[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int find_idx(input int e);
    foreach (mq[i]) if (mq[i].idx == e) return i;
    return -1;
  endfunction

  task automatic idle();
    rst_in = 0; rdy_in = 1;
    issue_valid = 0; issue_type = 0; issue_rd = 0; issue_pc = 0;
    issue_pred_jump = 0; issue_ready = 0; issue_value = 0;
    wb_valid = 0; wb_entry = 0; wb_value = 0; wb_jump = 0; wb_target = 0;
    get_rob_entry1 = 0; get_rob_entry2 = 0;
  endtask

  task automatic drive_issue(input logic [1:0] t, input logic [4:0] rd, input logic [31:0] pc,
                             input logic pj, input logic r, input logic [31:0] v);
    issue_valid = 1; issue_type = t; issue_rd = rd; issue_pc = pc;
    issue_pred_jump = pj; issue_ready = r; issue_value = v;
  endtask

  task automatic drive_wb(input int e, input logic [31:0] v, input logic j, input logic [31:0] tg);
    wb_valid = 1; wb_entry = RB'(e); wb_value = v; wb_jump = j; wb_target = tg;
  endtask

  task automatic chk_query(input string tag, input logic [RB-1:0] e, input logic r_o,
                           input logic [31:0] v_o);
    int p;
    if (wb_valid && wb_entry == e) begin
      chk({tag, "_bypass_ready"}, r_o, 1);
      chk({tag, "_bypass_value"}, v_o, wb_value);
    end else begin
      p = find_idx(int'(e));
      if (p >= 0) begin
        chk({tag, "_ready"}, r_o, mq[p].rdy);
        if (mq[p].rdy) chk({tag, "_value"}, v_o, mq[p].val);
      end
    end
  endtask

  // Advances the model across one clock edge using the inputs currently driven.
  task automatic model_edge();
    ent_t h, n;
    logic was_clr, acc, flush;
    int p;
    if (rst_in) begin
      mq.delete(); m_tail = 0; m_clear = 0;
      e_creg = 0; e_st = 0; e_clr = 0; e_exit = 0;
      e_cid = 0; e_cdata = 0; e_clrpc = 0; e_centry = 0; e_stentry = 0;
      return;
    end
    if (!rdy_in) return;
    was_clr = m_clear;
    m_clear = 0;
    acc = issue_valid && (mq.size() < N) && !was_clr;
    e_creg = 0; e_st = 0; e_clr = 0; flush = 0;
    if (mq.size() > 0 && mq[0].rdy) begin
      h = mq.pop_front();
      if (h.typ == 0 || h.typ == 2) begin
        e_creg = 1; e_cid = h.rd; e_cdata = (h.rd == 0) ? 32'd0 : h.val; e_centry = h.idx;
      end
      if (h.typ == 1) begin e_st = 1; e_stentry = h.idx; end
      if (h.typ == 3) e_exit = 1;
      if (h.typ == 2 && h.jmp != h.pred) begin
        flush = 1; e_clr = 1; e_clrpc = h.jmp ? h.tgt : h.pc + 32'd4;
      end
    end
    if (flush) begin
      mq.delete(); m_tail = 0; m_clear = 1;
    end else begin
      if (wb_valid && !was_clr) begin
        p = find_idx(int'(wb_entry));
        if (p >= 0) begin
          mq[p].rdy = 1; mq[p].val = wb_value; mq[p].jmp = wb_jump; mq[p].tgt = wb_target;
        end
      end
      if (acc) begin
        n.idx = m_tail; n.typ = issue_type; n.rd = issue_rd; n.pc = issue_pc;
        n.pred = issue_pred_jump; n.rdy = issue_ready; n.val = issue_value;
        n.jmp = issue_pred_jump; n.tgt = 0;
        mq.push_back(n);
        m_tail = (m_tail + 1) % N;
      end
    end
  endtask

  task automatic check_regs();
    chk("commit_reg", rob_commit_reg, e_creg);
    if (e_creg) begin
      chk("commit_reg_id", commit_reg_id, e_cid);
      chk("commit_reg_data", commit_reg_data, e_cdata);
      chk("commit_rob_entry", commit_rob_entry, e_centry);
    end
    chk("commit_store", commit_store, e_st);
    if (e_st) chk("commit_store_entry", commit_store_entry, e_stentry);
    chk("clear_up", rob_clear_up, e_clr);
    if (e_clr) chk("clear_pc", clear_pc, e_clrpc);
    chk("exit_out", exit_out, e_exit);
  endtask

  // Inputs are driven just after a rising edge; this checks them, crosses the next edge and
  // checks the registered outputs 1 time unit later.
  task automatic cycle();
    logic acc, exp_ir;
    #1;
    if (!rst_in) begin
      chk("full", full, mq.size() == N);
      chk("issue_entry", issue_entry, m_tail);
      acc = issue_valid && (mq.size() < N) && !m_clear;
      exp_ir = acc && issue_rd != 0 && (issue_type == 0 || issue_type == 2);
      chk("rob_issue_reg", rob_issue_reg, exp_ir);
      if (exp_ir) begin
        chk("issue_reg_id", issue_reg_id, issue_rd);
        chk("issue_rob_entry", issue_rob_entry, m_tail);
      end
      chk_query("q1", get_rob_entry1, ready1, value1);
      chk_query("q2", get_rob_entry2, ready2, value2);
    end
    model_edge();
    @(posedge clk_in);
    #1;
    check_regs();
  endtask

  task automatic do_reset();
    idle();
    rst_in = 1;
    cycle();
    rst_in = 0;
  endtask

  initial begin
    int r, e, p;
    logic [1:0] t;
    logic j;
    idle();
    rst_in = 1;
    @(posedge clk_in);
    #1;

    // Reset state and single ready-at-issue REG commit.
    do_reset();
    chk("rst_commit_id", commit_reg_id, 0);
    chk("rst_commit_data", commit_reg_data, 0);
    chk("rst_commit_entry", commit_rob_entry, 0);
    chk("rst_store_entry", commit_store_entry, 0);
    chk("rst_clear_pc", clear_pc, 0);
    chk("rst_full", full, 0);
    chk("rst_issue_entry", issue_entry, 0);
    idle(); drive_issue(0, 5, 32'h0, 0, 1, 32'h1234);
    #1;
    chk("t1_issue_reg", rob_issue_reg, 1);
    chk("t1_issue_entry", issue_rob_entry, 0);
    cycle();
    idle(); cycle();
    chk("t1_commit", rob_commit_reg, 1);
    chk("t1_commit_id", commit_reg_id, 5);
    chk("t1_commit_data", commit_reg_data, 32'h1234);
    chk("t1_commit_entry", commit_rob_entry, 0);

    // Fill, overflow attempt, single drain and wrap-around.
    do_reset();
    for (int i = 0; i < N; i++) begin
      idle(); drive_issue(0, 5'(i + 1), 32'(i * 4), 0, 0, 0); cycle();
    end
    idle(); chk("t2_full", full, 1);
    drive_issue(0, 9, 32'h40, 0, 1, 32'h99); cycle();
    idle(); drive_wb(0, 32'hAA, 0, 0); cycle();
    idle(); cycle();
    chk("t2_commit", rob_commit_reg, 1);
    chk("t2_commit_entry", commit_rob_entry, 0);
    chk("t2_full_drop", full, 0);
    chk("t2_wrap_entry", issue_entry, 0);
    drive_issue(0, 3, 32'h44, 0, 0, 0); cycle();

    // Out-of-order writeback, in-order commit.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      idle(); drive_issue(0, 5'(10 + i), 32'(i * 4), 0, 0, 0); cycle();
    end
    idle(); drive_wb(2, 32'd22, 0, 0); cycle();
    idle(); drive_wb(1, 32'd21, 0, 0); cycle();
    idle(); drive_wb(0, 32'd20, 0, 0); cycle();
    for (int i = 0; i < 3; i++) begin
      idle(); cycle();
      chk("t3_order_entry", commit_rob_entry, i);
      chk("t3_order_pulse", rob_commit_reg, 1);
    end

    // Same-cycle CDB bypass on a query.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      idle(); drive_issue(0, 5'(i + 1), 0, 0, 0, 0); cycle();
    end
    idle(); drive_wb(3, 32'd7, 0, 0); get_rob_entry1 = 3;
    #1;
    chk("t4_bypass_ready", ready1, 1);
    chk("t4_bypass_value", value1, 7);
    cycle();

    // Mispredicted branch flushes younger entries.
    do_reset();
    idle(); drive_issue(2, 1, 32'h100, 0, 0, 0); cycle();
    idle(); drive_issue(0, 6, 32'h104, 0, 0, 0); cycle();
    idle(); drive_issue(0, 7, 32'h108, 0, 0, 0); cycle();
    idle(); drive_wb(1, 32'd11, 0, 0); cycle();
    idle(); drive_wb(2, 32'd12, 0, 0); cycle();
    idle(); drive_wb(0, 32'h104, 1, 32'h200); cycle();
    idle(); cycle();
    chk("t5_clear", rob_clear_up, 1);
    chk("t5_clear_pc", clear_pc, 32'h200);
    chk("t5_link_id", commit_reg_id, 1);
    idle(); drive_issue(0, 8, 32'h200, 0, 1, 32'd5);
    #1;
    chk("t5_issue_in_clear", rob_issue_reg, 0);
    cycle();
    chk("t5_clear_drop", rob_clear_up, 0);
    chk("t5_tail_reset", issue_entry, 0);
    idle(); cycle();
    chk("t5_no_younger_commit", rob_commit_reg, 0);

    // Stall with rdy_in low while a commit pulse is high.
    do_reset();
    idle(); drive_issue(0, 3, 0, 0, 1, 32'd33); cycle();
    idle(); drive_issue(0, 4, 4, 0, 1, 32'd44); cycle();
    for (int i = 0; i < 3; i++) begin
      idle(); rdy_in = 0; cycle();
      chk("t6_held_pulse", rob_commit_reg, 1);
      chk("t6_held_entry", commit_rob_entry, 0);
    end
    idle(); cycle();
    chk("t6_after_entry", commit_rob_entry, 1);
    chk("t6_after_id", commit_reg_id, 4);
    idle(); cycle();
    chk("t6_pulse_drop", rob_commit_reg, 0);

    // EXIT is sticky.
    do_reset();
    idle(); drive_issue(3, 0, 32'h300, 0, 1, 0); cycle();
    idle(); cycle();
    chk("t7_exit", exit_out, 1);
    idle(); cycle();
    chk("t7_exit_sticky", exit_out, 1);

    // Random traffic against the model.
    do_reset();
    for (int c = 0; c < 600; c++) begin
      idle();
      if ($urandom_range(0, 9) == 0) rdy_in = 0;
      if ($urandom_range(0, 2) != 0) begin
        r = $urandom_range(0, 9);
        t = (r < 6) ? 2'd0 : (r < 8) ? 2'd1 : 2'd2;
        drive_issue(t, 5'($urandom_range(0, 31)), $urandom, 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 3) == 0), $urandom);
      end
      unr.delete();
      foreach (mq[i]) if (!mq[i].rdy) unr.push_back(mq[i].idx);
      if (unr.size() > 0 && $urandom_range(0, 1) == 1) begin
        e = unr[$urandom_range(0, unr.size() - 1)];
        p = find_idx(e);
        j = ($urandom_range(0, 3) == 0) ? !mq[p].pred : mq[p].pred;
        drive_wb(e, $urandom, j, $urandom);
      end else if ($urandom_range(0, 7) == 0) begin
        drive_wb($urandom_range(0, N - 1), $urandom, 1'($urandom_range(0, 1)), $urandom);
      end
      if (mq.size() > 0) get_rob_entry1 = RB'(mq[$urandom_range(0, mq.size() - 1)].idx);
      get_rob_entry2 = RB'($urandom_range(0, N - 1));
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
